// File: rtl/display_scheduler.sv
// Purpose: arbitrates the 8-digit display between live src0, message src1 and alert src2 (src2 > src1).
// Latency: all outputs registered; src0 passthrough and message accept take effect one cycle later.
// Backpressure: src1/src2 hold req until a one-cycle ack; losers and same-priority requests wait for the display.
module display_scheduler #(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_TICKS  = 2000,
    parameter int GAP_TICKS   = 100,
    parameter int BLINK_TICKS = 250,
    parameter int BLINK_EN    = 1
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [31:0] src0_digits,
    input  logic        src0_disp8,
    input  logic        src1_req,
    input  logic [31:0] src1_digits,
    input  logic        src1_disp8,
    output logic        src1_ack,
    input  logic        src2_req,
    input  logic [31:0] src2_digits,
    input  logic        src2_disp8,
    output logic        src2_ack,
    output logic [3:0]  BCD0,
    output logic [3:0]  BCD1,
    output logic [3:0]  BCD2,
    output logic [3:0]  BCD3,
    output logic [3:0]  BCD4,
    output logic [3:0]  BCD5,
    output logic [3:0]  BCD6,
    output logic [3:0]  BCD7,
    output logic        disp8,
    output logic        off,
    output logic        busy,
    output logic [1:0]  active_src
);

    localparam int PW = (TICK_DIV    > 0) ? $clog2(TICK_DIV + 1)    : 1;
    localparam int HW = (HOLD_TICKS  > 0) ? $clog2(HOLD_TICKS + 1)  : 1;
    localparam int GW = (GAP_TICKS   > 0) ? $clog2(GAP_TICKS + 1)   : 1;
    localparam int BW = (BLINK_TICKS > 0) ? $clog2(BLINK_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_TICKS);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [HW-1:0]   r_hold_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [BW-1:0]   r_blink_cnt;

    logic [31:0]     r_bcd, w_bcd_nxt;
    logic            r_disp8, w_disp8_nxt;
    logic            r_off, w_off_nxt;
    logic            r_busy, w_busy_nxt;
    logic [1:0]      r_active_src, w_active_nxt;
    logic            r_src1_ack, r_src2_ack, w_src1_ack_nxt, w_src2_ack_nxt;

    logic            w_enter_show, w_grant2, w_enter_gap, w_entry;
    logic            w_tick, w_req1, w_req2, w_any_req, w_hold_done, w_gap_done, w_preempt;
    logic            w_blink_flip;

    // A req seen while its own ack is high is the already-accepted request, not a new one.
    assign w_req1      = src1_req & ~r_src1_ack;
    assign w_req2      = src2_req & ~r_src2_ack;
    assign w_any_req   = w_req1 | w_req2;
    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_hold_done = w_tick && (r_hold_cnt <= HOLD_ONE);
    assign w_gap_done  = w_tick && (r_gap_cnt <= GAP_ONE);
    assign w_preempt   = (r_active_src == 2'd1) && w_req2;
    assign w_blink_flip = (BLINK_EN != 0) && (r_state == S_SHOW) && (r_active_src == 2'd2)
                          && w_tick && (r_blink_cnt <= BLINK_ONE);
    assign w_enter_gap = (w_state_nxt == S_GAP) && (r_state != S_GAP);
    assign w_entry     = w_enter_show || w_enter_gap
                         || ((w_state_nxt == S_IDLE) && (r_state != S_IDLE));

    // State register.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: arbitration, timed exits and src2-over-src1 preemption.
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_show = 1'b0;
        w_grant2     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt  = S_SHOW;
                    w_enter_show = 1'b1;
                    w_grant2     = w_req2;
                end
            end
            S_SHOW: begin
                if (w_preempt) begin
                    w_enter_show = 1'b1;
                    w_grant2     = 1'b1;
                end else if (w_hold_done) begin
                    if (GAP_TICKS != 0) begin
                        w_state_nxt = S_GAP;
                    end else if (w_any_req) begin
                        w_enter_show = 1'b1;
                        w_grant2     = w_req2;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (w_preempt) begin
                    w_state_nxt  = S_SHOW;
                    w_enter_show = 1'b1;
                    w_grant2     = 1'b1;
                end else if (w_gap_done) begin
                    if (w_any_req) begin
                        w_state_nxt  = S_SHOW;
                        w_enter_show = 1'b1;
                        w_grant2     = w_req2;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next output values: latch winner on accept, follow src0 in IDLE, blank in GAP, blink alerts.
    always_comb begin
        w_bcd_nxt      = r_bcd;
        w_disp8_nxt    = r_disp8;
        w_off_nxt      = r_off;
        w_busy_nxt     = r_busy;
        w_active_nxt   = r_active_src;
        w_src1_ack_nxt = 1'b0;
        w_src2_ack_nxt = 1'b0;
        if (w_enter_show) begin
            w_bcd_nxt      = w_grant2 ? src2_digits : src1_digits;
            w_disp8_nxt    = w_grant2 ? src2_disp8  : src1_disp8;
            w_active_nxt   = w_grant2 ? 2'd2 : 2'd1;
            w_src2_ack_nxt = w_grant2;
            w_src1_ack_nxt = ~w_grant2;
            w_off_nxt      = 1'b0;
            w_busy_nxt     = 1'b1;
        end else begin
            case (w_state_nxt)
                S_IDLE: begin
                    w_bcd_nxt    = src0_digits;
                    w_disp8_nxt  = src0_disp8;
                    w_off_nxt    = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_active_nxt = 2'd0;
                end
                S_GAP: begin
                    w_off_nxt  = 1'b1;
                    w_busy_nxt = 1'b1;
                end
                default: begin
                    if (w_blink_flip) w_off_nxt = ~r_off;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_bcd        <= 32'd0;
            r_disp8      <= 1'b0;
            r_off        <= 1'b1;
            r_busy       <= 1'b0;
            r_active_src <= 2'd0;
            r_src1_ack   <= 1'b0;
            r_src2_ack   <= 1'b0;
        end else begin
            r_bcd        <= w_bcd_nxt;
            r_disp8      <= w_disp8_nxt;
            r_off        <= w_off_nxt;
            r_busy       <= w_busy_nxt;
            r_active_src <= w_active_nxt;
            r_src1_ack   <= w_src1_ack_nxt;
            r_src2_ack   <= w_src2_ack_nxt;
        end
    end

    // Prescaler and tick counters; all restart on state entry so durations are whole ticks.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_blink_cnt <= '0;
        end else begin
            if (w_entry || w_tick) r_presc <= '0;
            else                   r_presc <= r_presc + 1'b1;

            if (w_enter_show)
                r_hold_cnt <= HOLD_LOAD;
            else if ((r_state == S_SHOW) && w_tick && (r_hold_cnt != '0))
                r_hold_cnt <= r_hold_cnt - 1'b1;

            if (w_enter_gap)
                r_gap_cnt <= GAP_LOAD;
            else if ((r_state == S_GAP) && w_tick && (r_gap_cnt != '0))
                r_gap_cnt <= r_gap_cnt - 1'b1;

            if (w_enter_show || ((r_state == S_SHOW) && w_tick && (r_blink_cnt <= BLINK_ONE)))
                r_blink_cnt <= BLINK_LOAD;
            else if ((r_state == S_SHOW) && w_tick)
                r_blink_cnt <= r_blink_cnt - 1'b1;
        end
    end

    assign BCD0       = r_bcd[3:0];
    assign BCD1       = r_bcd[7:4];
    assign BCD2       = r_bcd[11:8];
    assign BCD3       = r_bcd[15:12];
    assign BCD4       = r_bcd[19:16];
    assign BCD5       = r_bcd[23:20];
    assign BCD6       = r_bcd[27:24];
    assign BCD7       = r_bcd[31:28];
    assign disp8      = r_disp8;
    assign off        = r_off;
    assign busy       = r_busy;
    assign active_src = r_active_src;
    assign src1_ack   = r_src1_ack;
    assign src2_ack   = r_src2_ack;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, BLINK_TICKS=1.
// A second instance with BLINK_EN=0 shares all inputs to compare steady alert display.
module tb_display_scheduler;

    logic        clk;
    logic        reset;
    logic [31:0] src0_digits;
    logic        src0_disp8;
    logic        src1_req;
    logic [31:0] src1_digits;
    logic        src1_disp8;
    logic        src2_req;
    logic [31:0] src2_digits;
    logic        src2_disp8;

    logic        src1_ack, src2_ack, disp8, off, busy;
    logic [1:0]  active_src;
    logic [3:0]  b0, b1, b2, b3, b4, b5, b6, b7;

    logic        nb_src1_ack, nb_src2_ack, nb_disp8, nb_off, nb_busy;
    logic [1:0]  nb_active_src;
    logic [3:0]  n0, n1, n2, n3, n4, n5, n6, n7;

    logic [31:0] bcd;
    assign bcd = {b7, b6, b5, b4, b3, b2, b1, b0};

    int checks = 0;
    int errors = 0;
    int n;

    display_scheduler #(
        .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2), .BLINK_TICKS(1), .BLINK_EN(1)
    ) dut (
        .CLK100MHZ(clk), .reset(reset),
        .src0_digits(src0_digits), .src0_disp8(src0_disp8),
        .src1_req(src1_req), .src1_digits(src1_digits), .src1_disp8(src1_disp8), .src1_ack(src1_ack),
        .src2_req(src2_req), .src2_digits(src2_digits), .src2_disp8(src2_disp8), .src2_ack(src2_ack),
        .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3), .BCD4(b4), .BCD5(b5), .BCD6(b6), .BCD7(b7),
        .disp8(disp8), .off(off), .busy(busy), .active_src(active_src)
    );

    display_scheduler #(
        .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2), .BLINK_TICKS(1), .BLINK_EN(0)
    ) dut_nb (
        .CLK100MHZ(clk), .reset(reset),
        .src0_digits(src0_digits), .src0_disp8(src0_disp8),
        .src1_req(src1_req), .src1_digits(src1_digits), .src1_disp8(src1_disp8), .src1_ack(nb_src1_ack),
        .src2_req(src2_req), .src2_digits(src2_digits), .src2_disp8(src2_disp8), .src2_ack(nb_src2_ack),
        .BCD0(n0), .BCD1(n1), .BCD2(n2), .BCD3(n3), .BCD4(n4), .BCD5(n5), .BCD6(n6), .BCD7(n7),
        .disp8(nb_disp8), .off(nb_off), .busy(nb_busy), .active_src(nb_active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge.
    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        src0_digits = 32'd0;
        src0_disp8  = 1'b0;
        src1_req    = 1'b0;
        src1_digits = 32'd0;
        src1_disp8  = 1'b0;
        src2_req    = 1'b0;
        src2_digits = 32'd0;
        src2_disp8  = 1'b0;

        // Reset state
        #2;
        chk("rst_bcd", bcd, 32'd0);
        chk("rst_off", {31'd0, off}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_disp8", {31'd0, disp8}, 32'd0);
        chk("rst_active", {30'd0, active_src}, 32'd0);
        chk("rst_acks", {30'd0, src1_ack, src2_ack}, 32'd0);

        // Idle passthrough
        step(1);
        reset       = 1'b0;
        src0_digits = 32'h1234_5678;
        src0_disp8  = 1'b1;
        step(1);
        chk("idle_bcd", bcd, 32'h1234_5678);
        chk("idle_disp8", {31'd0, disp8}, 32'd1);
        chk("idle_off", {31'd0, off}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        src0_digits = 32'h8765_4321;
        src0_disp8  = 1'b0;
        step(1);
        chk("idle2_bcd", bcd, 32'h8765_4321);
        chk("idle2_disp8", {31'd0, disp8}, 32'd0);

        // Single src1 message
        src1_req    = 1'b1;
        src1_digits = 32'h0000_00AB;
        step(1);
        chk("msg_ack1", {31'd0, src1_ack}, 32'd1);
        chk("msg_bcd", bcd, 32'h0000_00AB);
        chk("msg_active", {30'd0, active_src}, 32'd1);
        chk("msg_busy", {31'd0, busy}, 32'd1);
        src1_req    = 1'b0;
        src0_digits = 32'h5555_6666;
        step(1);
        chk("msg_ack1_pulse", {31'd0, src1_ack}, 32'd0);
        step(10);
        chk("msg_show_last_off", {31'd0, off}, 32'd0);
        chk("msg_show_last_bcd", bcd, 32'h0000_00AB);
        step(1);
        chk("msg_gap_off", {31'd0, off}, 32'd1);
        chk("msg_gap_bcd", bcd, 32'h0000_00AB);
        step(7);
        chk("msg_gap_last_off", {31'd0, off}, 32'd1);
        chk("msg_gap_last_busy", {31'd0, busy}, 32'd1);
        step(1);
        chk("msg_idle_busy", {31'd0, busy}, 32'd0);
        chk("msg_idle_off", {31'd0, off}, 32'd0);
        chk("msg_idle_bcd", bcd, 32'h5555_6666);
        chk("msg_idle_active", {30'd0, active_src}, 32'd0);

        // Simultaneous requests plus alert blink
        src1_req    = 1'b1;
        src1_digits = 32'h1111_1111;
        src2_req    = 1'b1;
        src2_digits = 32'h2222_2222;
        src2_disp8  = 1'b1;
        step(1);
        chk("sim_ack2", {31'd0, src2_ack}, 32'd1);
        chk("sim_ack1_low", {31'd0, src1_ack}, 32'd0);
        chk("sim_active", {30'd0, active_src}, 32'd2);
        chk("sim_bcd", bcd, 32'h2222_2222);
        chk("sim_disp8", {31'd0, disp8}, 32'd1);
        src2_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(1);
            if ((i % 4) == 1) begin
                chk("blink_off", {31'd0, off}, ((i / 4) == 1) ? 32'd1 : 32'd0);
                chk("noblink_off", {31'd0, nb_off}, 32'd0);
            end
        end
        n = 11;
        while (!src1_ack && n < 40) begin
            step(1);
            n++;
        end
        chk("sim_ack1_delay", 32'(n), 32'd20);
        chk("sim_src1_bcd", bcd, 32'h1111_1111);
        chk("sim_src1_active", {30'd0, active_src}, 32'd1);
        src1_req = 1'b0;

        // src2 preempts src1 five cycles into SHOW
        step(5);
        src2_req    = 1'b1;
        src2_digits = 32'h3333_3333;
        step(1);
        chk("pre_ack2", {31'd0, src2_ack}, 32'd1);
        chk("pre_active", {30'd0, active_src}, 32'd2);
        chk("pre_bcd", bcd, 32'h3333_3333);
        chk("pre_no_gap", {31'd0, off}, 32'd0);
        src2_req = 1'b0;
        step(11);
        chk("pre_show_last_busy", {31'd0, busy}, 32'd1);
        chk("pre_show_last_off", {31'd0, off}, 32'd0);
        chk("pre_show_last_bcd", bcd, 32'h3333_3333);
        step(1);
        chk("pre_gap_off", {31'd0, off}, 32'd1);
        step(8);
        chk("pre_idle_busy", {31'd0, busy}, 32'd0);

        // Async reset mid-SHOW with a pending src1 request
        src1_req    = 1'b1;
        src1_digits = 32'h4444_4444;
        step(1);
        chk("rs_ack1", {31'd0, src1_ack}, 32'd1);
        src1_req = 1'b0;
        step(3);
        src1_req = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("rs_async_off", {31'd0, off}, 32'd1);
        chk("rs_async_bcd", bcd, 32'd0);
        chk("rs_async_busy", {31'd0, busy}, 32'd0);
        chk("rs_async_active", {30'd0, active_src}, 32'd0);
        step(1);
        chk("rs_held_noack", {31'd0, src1_ack}, 32'd0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("rs_release_ack1", {31'd0, src1_ack}, 32'd1);
        chk("rs_release_bcd", bcd, 32'h4444_4444);
        chk("rs_release_active", {30'd0, active_src}, 32'd1);
        src1_req = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Arbitrates the 8-digit seven-segment display between three content sources and sequences what the TDM display driver shows.
- Source 0 is a live background value, such as a counter or calculator operand, shown whenever nothing else is scheduled.
- Sources 1 (status message) and 2 (alert) request timed one-shot messages through a req/ack handshake.
- Outputs feed the display driver's BCD0..BCD7, disp8 and off inputs directly.

Parameters:
- TICK_DIV, 100000, clock cycles per scheduler tick (1 ms at 100 MHz); must be ≥2.
- HOLD_TICKS, 2000, ticks a granted message stays on the display.
- GAP_TICKS, 100, ticks of blanked display after each message.
- BLINK_TICKS, 250, ticks per on/off phase while an alert (source 2) is shown.
- BLINK_EN, 1, 1 enables alert blinking; 0 shows alerts steadily.

Ports:
- CLK100MHZ, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- src0_digits, in, 32, live background digits; nibble k maps to BCDk.
- src0_disp8, in, 1, 8-digit mode for background.
- src1_req, in, 1, message request, level held until ack.
- src1_digits, in, 32, message digits, sampled on accept.
- src1_disp8, in, 1, 8-digit mode for message.
- src1_ack, out, 1, one-cycle accept pulse.
- src2_req, src2_digits, src2_disp8, src2_ack, same as src1, alert source.
- BCD0..BCD7, out, 4 each, digit values to the display driver.
- disp8, out, 1, 8-digit mode to the display driver.
- off, out, 1, blank all displays.
- busy, out, 1, high in SHOW or GAP.
- active_src, out, 2, source currently owning the display (0, 1 or 2).

Behaviour:
- All outputs are registered.
- Reset values: BCD0..7=0, disp8=0, off=1, acks=0, busy=0, active_src=0, state IDLE, prescaler=0.
- From the first clock after reset in IDLE: BCD/disp8 follow src0 with 1-cycle latency, off=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick = 1 when count = TICK_DIV-1.
  - Cleared on every state entry, so state durations are exact multiples of TICK_DIV.
- States and transitions:
  - IDLE: show src0 live. Any req makes the state SHOW on the next edge.
  - SHOW: latched message displayed. Tick counter loaded with HOLD_TICKS on entry; leave after exactly HOLD_TICKS×TICK_DIV cycles, to GAP.
  - GAP: off=1, busy=1, BCD holds the last message. Lasts GAP_TICKS×TICK_DIV cycles. Then SHOW if any req is pending, else IDLE. GAP_TICKS=0 skips GAP.
- Accept:
  - On the accept edge, the winner's digits/disp8 are latched into BCD/disp8, its ack pulses high for exactly that following cycle, and active_src is set.
  - A requester must drop req after ack. A req still high 1 cycle after ack counts as a new request.
- Priority: src2 > src1. Simultaneous requests: src2 is granted; src1 is served after src2's SHOW+GAP.
- Preemption:
  - src2_req during SHOW or GAP of a src1 message: immediate jump to SHOW with src2, no gap, counters reloaded.
  - The src1 message is discarded; it was already acked.
  - src1_req never preempts. A new src2_req during a src2 SHOW waits for GAP end.
- Blink:
  - Applies in SHOW with active_src=2 and BLINK_EN=1.
  - off starts 0 and toggles every BLINK_TICKS ticks. off=0 on exit from SHOW to IDLE.
- Counter widths: $clog2(param+1). No wrap; each counter saturates at 0 and is reloaded only on state entry.
- Reset mid-message: immediate return to reset values. Pending reqs are re-arbitrated from IDLE after reset release, and are not acked before.

Test Plan:
(Benches use TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, BLINK_TICKS=1.)
- Idle passthrough: src0_digits=32'h1234_5678, src0_disp8=1 → next cycle BCD7..BCD0=1,2,3,4,5,6,7,8, disp8=1, off=0, busy=0.
- Single message: src1_req with 32'h0000_00AB, held until ack.
  - Expected: src1_ack for 1 cycle, BCD1=A, BCD0=B, active_src=1.
  - Display held 12 cycles, then off=1 for 8 cycles, then back to src0.
- Simultaneous requests: src1_req and src2_req in the same cycle.
  - Expected: src2_ack first; src1_ack exactly 20 cycles later (12 SHOW + 8 GAP).
- Preemption: src2_req issued 5 cycles into src1's SHOW.
  - Expected: src2_ack next edge, active_src=2, 12 fresh SHOW cycles, no gap between messages.
- Blink: a src2 message shows off=0,1,0 in 4-cycle phases across SHOW. With BLINK_EN=0, off stays 0.
- Async reset asserted mid-SHOW (between clock edges) → outputs return to reset values immediately, no ack; after release, held src1_req is acked via IDLE→SHOW.
